// File: rtl/onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter for a single-port on-chip RAM with 1-cycle read latency.
// Master 0 has priority; master 1 is guaranteed a grant after HOLD_MAX consecutive m0 grants.
module onchip_memory_arbiter #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BE_W     = 4,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic              req0, req1, hold_hit;
  logic              gnt0, gnt1, gnt_any, gnt_wr;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              pend_vld_q, pend_own_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign hold_hit = (starve_q == 4'(HOLD_MAX));

  always_comb begin
    gnt0    = ~reset & req0 & ~(req1 & hold_hit);
    gnt1    = ~reset & req1 & ~gnt0;
    gnt_any = gnt0 | gnt1;
    gnt_wr  = (gnt0 & m0_write) | (gnt1 & m1_write);
  end

  always_comb begin
    starve_d = starve_q;
    if (!req1 || gnt1) begin
      starve_d = 4'd0;
    end else if (gnt0 && !hold_hit) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Address/data/byteenable hold their last granted value when idle.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (gnt0) begin
      addr_d  = m0_address;
      wdata_d = m0_writedata;
      be_d    = m0_write ? m0_byteenable : {BE_W{1'b1}};
    end else if (gnt1) begin
      addr_d  = m1_address;
      wdata_d = m1_writedata;
      be_d    = m1_write ? m1_byteenable : {BE_W{1'b1}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q   <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      pend_vld_q <= 1'b0;
      pend_own_q <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      // A read+write on one master is a write, so it never returns data.
      pend_vld_q <= gnt_any & ~gnt_wr;
      pend_own_q <= gnt1;
      if (pend_vld_q && !pend_own_q) rdata0_q <= mem_readdata;
      if (pend_vld_q && pend_own_q)  rdata1_q <= mem_readdata;
    end
  end

  always_comb begin
    mem_address      = addr_d;
    mem_writedata    = wdata_d;
    mem_byteenable   = be_d;
    mem_chipselect   = gnt_any;
    mem_write        = gnt_wr;
    mem_clken        = ~reset;

    m0_waitrequest   = reset | (req0 & ~gnt0);
    m1_waitrequest   = reset | (req1 & ~gnt1);

    m0_readdatavalid = pend_vld_q & ~pend_own_q;
    m1_readdatavalid = pend_vld_q & pend_own_q;
    m0_readdata      = m0_readdatavalid ? mem_readdata : rdata0_q;
    m1_readdata      = m1_readdatavalid ? mem_readdata : rdata1_q;
  end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench for onchip_memory_arbiter: RAM model, read-return scoreboard and
// a negedge monitor that pops expected read data whenever a readdatavalid appears.
module tb_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        mem_chipselect, mem_write, mem_clken;

  always #5 clk = ~clk;

  onchip_memory_arbiter #(.ADDR_W(15), .DATA_W(32), .BE_W(4), .HOLD_MAX(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // Single-port RAM: registered address, unregistered q.
  logic [31:0] ram [0:32767];
  logic [14:0] ram_a = '0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end
      ram_a <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_a];

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;
  int ncyc  = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic owner, input logic [31:0] data);
    sb.push_back('{owner, data, ncyc + 1});
  endtask

  always @(negedge clk) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      n_vec++;
      if (m0_readdatavalid && m1_readdatavalid) begin
        n_bad++;
        $display("FAIL rdvalid_both: both readdatavalid high at cycle %0d", ncyc);
      end else if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rdvalid_unexpected: m%0d valid at cycle %0d, none expected",
                 m1_readdatavalid, ncyc);
      end else begin
        exp_t e;
        logic [31:0] d;
        e = sb.pop_front();
        d = m1_readdatavalid ? m1_readdata : m0_readdata;
        if (m1_readdatavalid !== e.owner || d !== e.data || ncyc != e.due) begin
          n_bad++;
          $display("FAIL rdata: got m%0d 0x%08h cycle %0d expected m%0d 0x%08h cycle %0d",
                   m1_readdatavalid, d, ncyc, e.owner, e.data, e.due);
        end
      end
    end
  end

  task automatic set_master(input int m, input logic rd, input logic wr, input logic [14:0] a,
                            input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic do_acc(input int m, input logic rd, input logic wr, input logic [14:0] a,
                        input logic [3:0] be, input logic [31:0] d, input logic [31:0] exp_rd,
                        output int waits);
    bit acc;
    acc   = 1'b0;
    waits = 0;
    set_master(m, rd, wr, a, be, d);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if ((m == 0) ? !m0_waitrequest : !m1_waitrequest) begin
        acc = 1'b1;
        check("mem_drive", {mem_chipselect, mem_write, mem_byteenable, mem_address},
              {1'b1, wr, (wr ? be : 4'hF), a});
        if (rd && !wr) push(m[0], exp_rd);
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: m%0d never accepted, got %0d waits expected < 20", m, waits);
    end
    set_master(m, 1'b0, 1'b0, a, be, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  w;
    int  m1_waits;
    bit  g1;
    reset = 1'b1;
    set_master(0, 1'b0, 1'b0, '0, 4'hF, '0);
    set_master(1, 1'b0, 1'b0, '0, 4'hF, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wait",  {m0_waitrequest, m1_waitrequest}, 2'b11);
    check("rst_valid", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    check("rst_mem",   {mem_chipselect, mem_write, mem_clken}, 3'b000);
    check("rst_rdata", {m0_readdata, m1_readdata}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: m0 write then read back, first cycle after reset.
    do_acc(0, 1'b0, 1'b1, 15'h0010, 4'hF, 32'hDEADBEEF, 32'h0, w);
    check("t1_wr_wait", w, 0);
    do_acc(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0, 32'hDEADBEEF, w);
    check("t1_rd_wait", w, 0);

    // 2: byte lanes on m1; read byteenable is forced to all ones.
    do_acc(1, 1'b0, 1'b1, 15'h7FFF, 4'hF, 32'h11223344, 32'h0, w);
    do_acc(1, 1'b0, 1'b1, 15'h7FFF, 4'h5, 32'hAABBCCDD, 32'h0, w);
    do_acc(1, 1'b1, 1'b0, 15'h7FFF, 4'h5, 32'h0, 32'h11BB33DD, w);
    check("t2_rd_wait", w, 0);
    @(negedge clk);
    check("t2_m0_hold", m0_readdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // 4: interleaved pipelined reads.
    do_acc(0, 1'b0, 1'b1, 15'h0001, 4'hF, 32'h0000000A, 32'h0, w);
    do_acc(0, 1'b0, 1'b1, 15'h0002, 4'hF, 32'h0000000B, 32'h0, w);
    set_master(0, 1'b1, 1'b0, 15'h0001, 4'hF, 32'h0);
    @(negedge clk);
    check("t4_m0_wait", m0_waitrequest, 1'b0);
    push(1'b0, 32'h0000000A);
    @(posedge clk); #1;
    set_master(0, 1'b0, 1'b0, 15'h0001, 4'hF, 32'h0);
    set_master(1, 1'b1, 1'b0, 15'h0002, 4'hF, 32'h0);
    @(negedge clk);
    check("t4_m1_wait", m1_waitrequest, 1'b0);
    push(1'b1, 32'h0000000B);
    @(posedge clk); #1;
    set_master(1, 1'b0, 1'b0, 15'h0002, 4'hF, 32'h0);
    repeat (2) begin @(posedge clk); #1; end

    // 3: contention, expected grant pattern m0,m0,m0,m0,m1.
    set_master(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0);
    set_master(1, 1'b1, 1'b0, 15'h7FFF, 4'hF, 32'h0);
    m1_waits = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      g1 = ((k % 5) == 4);
      check("t3_grant", {m0_waitrequest, m1_waitrequest}, {g1, ~g1});
      if (!m0_waitrequest) push(1'b0, 32'hDEADBEEF);
      if (!m1_waitrequest) push(1'b1, 32'h11BB33DD);
      else m1_waits++;
      @(posedge clk); #1;
    end
    check("t3_m1_waits", m1_waits, 16);
    set_master(0, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);
    set_master(1, 1'b0, 1'b0, 15'h7FFF, 4'hF, 32'h0);
    repeat (2) begin @(posedge clk); #1; end

    // 6: read+write together is a write with no read return.
    do_acc(0, 1'b1, 1'b1, 15'h0005, 4'hF, 32'h00000005, 32'h0, w);
    @(negedge clk);
    check("t6_no_valid", m0_readdatavalid, 1'b0);
    check("t6_idle_hold", {mem_chipselect, mem_write, mem_address}, {1'b0, 1'b0, 15'h0005});
    @(posedge clk); #1;
    do_acc(0, 1'b1, 1'b0, 15'h0005, 4'hF, 32'h0, 32'h00000005, w);
    repeat (2) begin @(posedge clk); #1; end

    // 5: reset right after an accepted read drops its return.
    set_master(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0);
    @(negedge clk);
    check("t5_accept", m0_waitrequest, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_wait",  {m0_waitrequest, m1_waitrequest}, 2'b11);
    check("t5_rst_valid", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    check("t5_rst_rdata", {m0_readdata, m1_readdata}, 64'h0);
    check("t5_rst_mem",   {mem_chipselect, mem_write, mem_clken}, 3'b000);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_first_grant", m0_waitrequest, 1'b0);
    push(1'b0, 32'hDEADBEEF);
    @(posedge clk); #1;
    set_master(0, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);
    repeat (3) begin @(posedge clk); #1; end

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
